// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// FSM state encoding and default memory-wait limit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_t;

  localparam int HZ_MEM_WAIT_MAX = 15;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle.
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_LEN = 3,
  parameter int CNT_W        = 16
);

  logic [REG_ADDR_LEN-1:0] ID_rs1;
  logic [REG_ADDR_LEN-1:0] ID_rs2;
  logic [REG_ADDR_LEN-1:0] PR2_rd;
  logic ID_uses_rs1;
  logic ID_uses_rs2;
  logic PR2_MEM_read;
  logic PR2_RF_write_en;
  logic EX_branch_taken;
  logic PR3_MEM_read;
  logic PR3_MEM_write;
  logic mem_ready;

  logic pc_en;
  logic PR1_en;
  logic PR2_en;
  logic PR3_en;
  logic PR1_flush;
  logic PR2_flush;
  logic PR4_bubble;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_rs1, ID_rs2, PR2_rd,
    output ID_uses_rs1, ID_uses_rs2,
    output PR2_MEM_read, PR2_RF_write_en,
    output EX_branch_taken,
    output PR3_MEM_read, PR3_MEM_write,
    output mem_ready,
    input  pc_en, PR1_en, PR2_en, PR3_en,
    input  PR1_flush, PR2_flush, PR4_bubble,
    input  mem_timeout,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  ID_rs1, ID_rs2, PR2_rd,
    input  ID_uses_rs1, ID_uses_rs2,
    input  PR2_MEM_read, PR2_RF_write_en,
    input  EX_branch_taken,
    input  PR3_MEM_read, PR3_MEM_write,
    input  mem_ready,
    output pc_en, PR1_en, PR2_en, PR3_en,
    output PR1_flush, PR2_flush, PR4_bubble,
    output mem_timeout,
    output stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for hazard performance statistics.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch / memory-wait hazard controller for the 5-stage core.
// Perf counters built only with `HAZARD_PERF_CNT_EN defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_LEN = 3,
  parameter int MEM_WAIT_MAX = HZ_MEM_WAIT_MAX,
  parameter int CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  hz_state_t r_state;
  hz_state_t w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic r_timeout;
  logic w_to_err;

  logic [REG_ADDR_LEN-1:0] w_rd;
  logic w_mem_busy;
  logic w_hit1;
  logic w_hit2;
  logic w_load_use;

  logic w_pc_en;
  logic w_pr1_en;
  logic w_pr2_en;
  logic w_pr3_en;
  logic w_f1;
  logic w_f2;
  logic w_bub;

  assign w_rd = hz.PR2_rd;
  assign w_mem_busy = (hz.PR3_MEM_read | hz.PR3_MEM_write)
                    & ~hz.mem_ready;
  assign w_hit1 = hz.ID_uses_rs1 & (hz.ID_rs1 == w_rd);
  assign w_hit2 = hz.ID_uses_rs2 & (hz.ID_rs2 == w_rd);
  assign w_load_use = hz.PR2_MEM_read & hz.PR2_RF_write_en
                    & (w_rd != '0) & (w_hit1 | w_hit2);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_to_err    = 1'b0;
    w_pc_en     = 1'b0;
    w_pr1_en    = 1'b0;
    w_pr2_en    = 1'b0;
    w_pr3_en    = 1'b0;
    w_f1        = 1'b0;
    w_f2        = 1'b0;
    w_bub       = 1'b0;
    if (rst) begin
      if (r_state == ERR) begin
        w_bub = 1'b1;
      end else if (w_mem_busy) begin
        w_bub = 1'b1;
        if (r_wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1)) begin
          w_state_nxt = ERR;
          w_to_err    = 1'b1;
        end else begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = r_wait_cnt + 1'b1;
        end
      end else begin
        // MEM_WAIT with ready behaves as RUN this cycle
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
        w_pc_en     = 1'b1;
        w_pr1_en    = 1'b1;
        w_pr2_en    = 1'b1;
        w_pr3_en    = 1'b1;
        if (hz.EX_branch_taken) begin
          w_f1 = 1'b1;
          w_f2 = 1'b1;
        end else if (w_load_use) begin
          w_pc_en  = 1'b0;
          w_pr1_en = 1'b0;
          w_f2     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= r_timeout | w_to_err;
    end
  end

  assign hz.pc_en       = w_pc_en;
  assign hz.PR1_en      = w_pr1_en;
  assign hz.PR2_en      = w_pr2_en;
  assign hz.PR3_en      = w_pr3_en;
  assign hz.PR1_flush   = w_f1;
  assign hz.PR2_flush   = w_f2;
  assign hz.PR4_bubble  = w_bub;
  assign hz.mem_timeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_inc (~w_pc_en),
    .o_cnt (w_stall_cnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_inc (w_f1),
    .o_cnt (w_flush_cnt)
  );

  assign hz.stall_cycles = w_stall_cnt;
  assign hz.flush_count  = w_flush_cnt;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Counter expectations follow `HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en,PR1_en,PR2_en,PR3_en,PR1_flush,PR2_flush,PR4_bubble}
  localparam logic [6:0] C_OFF  = 7'b0000_000;
  localparam logic [6:0] C_NORM = 7'b1111_000;
  localparam logic [6:0] C_LU   = 7'b0011_010;
  localparam logic [6:0] C_BR   = 7'b1111_110;
  localparam logic [6:0] C_FRZ  = 7'b0000_001;

  logic clk;
  logic rst;
  int n_pass;
  int n_chk;
  logic [15:0] e_stall;
  logic [15:0] e_flush;
  logic [6:0] ctl;

  pipeline_hazard_ctrl_if #(.REG_ADDR_LEN(3), .CNT_W(16)) hz ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_LEN (3),
    .MEM_WAIT_MAX (15),
    .CNT_W        (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  assign ctl = {hz.pc_en, hz.PR1_en, hz.PR2_en, hz.PR3_en,
                hz.PR1_flush, hz.PR2_flush, hz.PR4_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  task automatic idle();
    hz.ID_rs1 = 3'd0;
    hz.ID_rs2 = 3'd0;
    hz.PR2_rd = 3'd0;
    hz.ID_uses_rs1 = 1'b0;
    hz.ID_uses_rs2 = 1'b0;
    hz.PR2_MEM_read = 1'b0;
    hz.PR2_RF_write_en = 1'b0;
    hz.EX_branch_taken = 1'b0;
    hz.PR3_MEM_read = 1'b0;
    hz.PR3_MEM_write = 1'b0;
    hz.mem_ready = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (ctl !== C_OFF) $display("FAIL rst_ctl: got %b want %b", ctl, C_OFF);
    else n_pass++;
    n_chk++;
    if (hz.mem_timeout !== 1'b0) $display("FAIL rst_to: got %b want 0", hz.mem_timeout);
    else n_pass++;
    n_chk++;
    if (hz.stall_cycles !== 16'd0) $display("FAIL rst_stall: got %0d want 0", hz.stall_cycles);
    else n_pass++;
    n_chk++;
    if (hz.flush_count !== 16'd0) $display("FAIL rst_flush: got %0d want 0", hz.flush_count);
    else n_pass++;
    nxt();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_NORM) $display("FAIL rst_rel: got %b want %b", ctl, C_NORM);
    else n_pass++;
    nxt();
  endtask

  task automatic test_load_use();
    hz.PR2_MEM_read = 1'b1;
    hz.PR2_RF_write_en = 1'b1;
    hz.PR2_rd = 3'd3;
    hz.ID_rs1 = 3'd5;
    hz.ID_uses_rs1 = 1'b1;
    hz.ID_rs2 = 3'd3;
    hz.ID_uses_rs2 = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_LU) $display("FAIL lu_rs2: got %b want %b", ctl, C_LU);
    else n_pass++;
    e_stall++;
    nxt();
    hz.PR2_MEM_read = 1'b0;
    hz.PR2_RF_write_en = 1'b0;
    hz.PR3_MEM_read = 1'b1;
    hz.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_NORM) $display("FAIL lu_after: got %b want %b", ctl, C_NORM);
    else n_pass++;
    n_chk++;
    if (hz.stall_cycles !== (PERF ? e_stall : 16'd0))
      $display("FAIL lu_stall_cnt: got %0d want %0d", hz.stall_cycles, PERF ? e_stall : 16'd0);
    else n_pass++;
    nxt();
    idle();
    hz.PR2_MEM_read = 1'b1;
    hz.PR2_RF_write_en = 1'b1;
    hz.PR2_rd = 3'd4;
    hz.ID_rs1 = 3'd4;
    hz.ID_uses_rs1 = 1'b0;
    hz.ID_rs2 = 3'd2;
    hz.ID_uses_rs2 = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_NORM) $display("FAIL lu_unused_rs1: got %b want %b", ctl, C_NORM);
    else n_pass++;
    nxt();
    hz.ID_uses_rs1 = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_LU) $display("FAIL lu_rs1: got %b want %b", ctl, C_LU);
    else n_pass++;
    e_stall++;
    nxt();
    hz.PR2_MEM_read = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_NORM) $display("FAIL lu_not_load: got %b want %b", ctl, C_NORM);
    else n_pass++;
    nxt();
    idle();
  endtask

  task automatic test_reg0();
    hz.PR2_MEM_read = 1'b1;
    hz.PR2_RF_write_en = 1'b1;
    hz.PR2_rd = 3'd0;
    hz.ID_rs1 = 3'd0;
    hz.ID_uses_rs1 = 1'b1;
    hz.ID_rs2 = 3'd0;
    hz.ID_uses_rs2 = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_NORM) $display("FAIL reg0: got %b want %b", ctl, C_NORM);
    else n_pass++;
    nxt();
    idle();
    @(negedge clk);
    n_chk++;
    if (hz.stall_cycles !== (PERF ? e_stall : 16'd0))
      $display("FAIL reg0_stall_cnt: got %0d want %0d", hz.stall_cycles, PERF ? e_stall : 16'd0);
    else n_pass++;
    nxt();
  endtask

  task automatic test_branch();
    hz.PR2_MEM_read = 1'b1;
    hz.PR2_RF_write_en = 1'b1;
    hz.PR2_rd = 3'd3;
    hz.ID_rs2 = 3'd3;
    hz.ID_uses_rs2 = 1'b1;
    hz.EX_branch_taken = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_BR) $display("FAIL br_prio: got %b want %b", ctl, C_BR);
    else n_pass++;
    e_flush++;
    nxt();
    idle();
    @(negedge clk);
    n_chk++;
    if (ctl !== C_NORM) $display("FAIL br_once: got %b want %b", ctl, C_NORM);
    else n_pass++;
    n_chk++;
    if (hz.flush_count !== (PERF ? e_flush : 16'd0))
      $display("FAIL br_flush_cnt: got %0d want %0d", hz.flush_count, PERF ? e_flush : 16'd0);
    else n_pass++;
    n_chk++;
    if (hz.stall_cycles !== (PERF ? e_stall : 16'd0))
      $display("FAIL br_stall_cnt: got %0d want %0d", hz.stall_cycles, PERF ? e_stall : 16'd0);
    else n_pass++;
    nxt();
  endtask

  task automatic test_mem_wait();
    hz.PR3_MEM_read = 1'b1;
    hz.mem_ready = 1'b0;
    hz.EX_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (ctl !== C_FRZ) $display("FAIL mw_frz%0d: got %b want %b", i, ctl, C_FRZ);
      else n_pass++;
      if (i == 1) begin
        n_chk++;
        if (dut.r_state !== MEM_WAIT)
          $display("FAIL mw_state: got %0d want %0d", dut.r_state, MEM_WAIT);
        else n_pass++;
      end
      e_stall++;
      nxt();
    end
    hz.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_BR) $display("FAIL mw_release: got %b want %b", ctl, C_BR);
    else n_pass++;
    e_flush++;
    nxt();
    idle();
    @(negedge clk);
    n_chk++;
    if (dut.r_state !== RUN) $display("FAIL mw_run: got %0d want %0d", dut.r_state, RUN);
    else n_pass++;
    n_chk++;
    if (dut.r_wait_cnt !== '0) $display("FAIL mw_wcnt: got %0d want 0", dut.r_wait_cnt);
    else n_pass++;
    n_chk++;
    if (hz.stall_cycles !== (PERF ? e_stall : 16'd0))
      $display("FAIL mw_stall_cnt: got %0d want %0d", hz.stall_cycles, PERF ? e_stall : 16'd0);
    else n_pass++;
    n_chk++;
    if (hz.flush_count !== (PERF ? e_flush : 16'd0))
      $display("FAIL mw_flush_cnt: got %0d want %0d", hz.flush_count, PERF ? e_flush : 16'd0);
    else n_pass++;
    nxt();
  endtask

  task automatic test_timeout();
    hz.PR3_MEM_write = 1'b1;
    hz.mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_chk++;
      if (ctl !== C_FRZ) $display("FAIL to14_frz%0d: got %b want %b", i, ctl, C_FRZ);
      else n_pass++;
      e_stall++;
      nxt();
    end
    hz.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_NORM) $display("FAIL to14_release: got %b want %b", ctl, C_NORM);
    else n_pass++;
    nxt();
    idle();
    @(negedge clk);
    n_chk++;
    if (hz.mem_timeout !== 1'b0) $display("FAIL to14_flag: got %b want 0", hz.mem_timeout);
    else n_pass++;
    nxt();
    hz.PR3_MEM_read = 1'b1;
    hz.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_chk++;
      if (ctl !== C_FRZ) $display("FAIL to15_frz%0d: got %b want %b", i, ctl, C_FRZ);
      else n_pass++;
      n_chk++;
      if (hz.mem_timeout !== 1'b0) $display("FAIL to15_early%0d: got %b want 0", i, hz.mem_timeout);
      else n_pass++;
      e_stall++;
      nxt();
    end
    idle();
    @(negedge clk);
    n_chk++;
    if (hz.mem_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", hz.mem_timeout);
    else n_pass++;
    n_chk++;
    if (dut.r_state !== ERR) $display("FAIL to_state: got %0d want %0d", dut.r_state, ERR);
    else n_pass++;
    n_chk++;
    if (ctl !== C_FRZ) $display("FAIL to_err_ctl: got %b want %b", ctl, C_FRZ);
    else n_pass++;
    e_stall++;
    nxt();
    hz.EX_branch_taken = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_FRZ) $display("FAIL to_err_br: got %b want %b", ctl, C_FRZ);
    else n_pass++;
    e_stall++;
    nxt();
    idle();
    @(negedge clk);
    n_chk++;
    if (hz.stall_cycles !== (PERF ? e_stall : 16'd0))
      $display("FAIL to_stall_cnt: got %0d want %0d", hz.stall_cycles, PERF ? e_stall : 16'd0);
    else n_pass++;
    n_chk++;
    if (hz.flush_count !== (PERF ? e_flush : 16'd0))
      $display("FAIL to_flush_cnt: got %0d want %0d", hz.flush_count, PERF ? e_flush : 16'd0);
    else n_pass++;
    n_chk++;
    if (hz.mem_timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", hz.mem_timeout);
    else n_pass++;
    nxt();
  endtask

  task automatic test_reset_recovery();
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    nxt();
    hz.PR3_MEM_read = 1'b1;
    hz.mem_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_FRZ) $display("FAIL rr_busy: got %b want %b", ctl, C_FRZ);
    else n_pass++;
    nxt();
    nxt();
    n_chk++;
    if (dut.r_state !== MEM_WAIT) $display("FAIL rr_in_wait: got %0d want %0d", dut.r_state, MEM_WAIT);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    e_stall = 16'd0;
    e_flush = 16'd0;
    n_chk++;
    if (ctl !== C_OFF) $display("FAIL rr_off: got %b want %b", ctl, C_OFF);
    else n_pass++;
    n_chk++;
    if (dut.r_state !== RUN) $display("FAIL rr_abort: got %0d want %0d", dut.r_state, RUN);
    else n_pass++;
    idle();
    nxt();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ctl !== C_NORM) $display("FAIL rr_first: got %b want %b", ctl, C_NORM);
    else n_pass++;
    n_chk++;
    if (hz.mem_timeout !== 1'b0) $display("FAIL rr_to: got %b want 0", hz.mem_timeout);
    else n_pass++;
    n_chk++;
    if (hz.stall_cycles !== e_stall) $display("FAIL rr_stall: got %0d want %0d", hz.stall_cycles, e_stall);
    else n_pass++;
    n_chk++;
    if (hz.flush_count !== e_flush) $display("FAIL rr_flush: got %0d want %0d", hz.flush_count, e_flush);
    else n_pass++;
    n_chk++;
    if (dut.r_state !== RUN) $display("FAIL rr_state: got %0d want %0d", dut.r_state, RUN);
    else n_pass++;
    nxt();
  endtask

  initial begin
    n_pass = 0;
    n_chk = 0;
    e_stall = 16'd0;
    e_flush = 16'd0;
    test_reset();
    test_load_use();
    test_reg0();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_recovery();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
